fetch_stage: RTL and testbench

//  Instruction-fetch stage of the RV32I core: owns the program counter.

---
 rtl/fetch_stage.sv | 111 +++++++++++
 tb/tb_fetch_stage.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses instruction memory and
// fills the IF/ID pipeline register. Handles stall, redirect and halt.
module fetch_stage #(
  parameter int               INS_ADDRESS = 9,
  parameter int               INS_W       = 32,
  parameter logic [31:0]      RESET_PC    = 32'h00000000,
  parameter logic [INS_W-1:0] NOP_INSTR   = 32'h00000013
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic [INS_ADDRESS-1:0] imem_ra,
  input  logic [INS_W-1:0]       imem_rd,
  input  logic                   stall,
  input  logic                   redirect_valid,
  input  logic [31:0]            redirect_pc,
  input  logic                   halt_req,
  output logic [31:0]            if_id_pc,
  output logic [INS_W-1:0]       if_id_instr,
  output logic                   if_id_valid,
  output logic                   pc_oob,
  output logic [31:0]            fetch_count,
  output logic                   halted
);

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [31:0]      pc, pc_next;
  logic [31:0]      if_id_pc_next;
  logic [INS_W-1:0] if_id_instr_next;
  logic             if_id_valid_next;
  logic [31:0]      fetch_count_next;
  logic [31:0]      redirect_aligned;

  // Branch targets are forced onto a word boundary before they reach the PC.
  assign redirect_aligned = redirect_pc & ~32'h3;

  // The memory address simply truncates the PC, so out-of-range PCs alias.
  assign imem_ra = pc[INS_ADDRESS-1:0];
  assign pc_oob  = (pc >> INS_ADDRESS) != 32'd0;
  assign halted  = (state == S_HALT);

  // State, PC and IF/ID register update; reset returns everything at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_BOOT;
      pc          <= RESET_PC;
      if_id_pc    <= 32'd0;
      if_id_instr <= NOP_INSTR;
      if_id_valid <= 1'b0;
      fetch_count <= 32'd0;
    end else begin
      state       <= state_next;
      pc          <= pc_next;
      if_id_pc    <= if_id_pc_next;
      if_id_instr <= if_id_instr_next;
      if_id_valid <= if_id_valid_next;
      fetch_count <= fetch_count_next;
    end
  end

  // Next-state logic; redirect beats halt, halt beats stall, stall beats fetch.
  always_comb begin
    state_next       = state;
    pc_next          = pc;
    if_id_pc_next    = if_id_pc;
    if_id_instr_next = if_id_instr;
    if_id_valid_next = if_id_valid;
    fetch_count_next = fetch_count;
    case (state)
      S_BOOT: begin
        state_next       = S_RUN;
        if_id_instr_next = NOP_INSTR;
        if_id_valid_next = 1'b0;
      end
      S_RUN: begin
        if (redirect_valid) begin
          pc_next          = redirect_aligned;
          if_id_instr_next = NOP_INSTR;
          if_id_valid_next = 1'b0;
        end else if (halt_req) begin
          state_next       = S_HALT;
          if_id_instr_next = NOP_INSTR;
          if_id_valid_next = 1'b0;
        end else if (!stall) begin
          if_id_pc_next    = pc;
          if_id_instr_next = imem_rd;
          if_id_valid_next = 1'b1;
          pc_next          = pc + 32'd4;
          fetch_count_next = fetch_count + 32'd1;
        end
      end
      S_HALT: begin
        if_id_instr_next = NOP_INSTR;
        if_id_valid_next = 1'b0;
        if (redirect_valid) begin
          pc_next    = redirect_aligned;
          state_next = S_RUN;
        end
      end
      default: begin
        state_next = S_BOOT;
      end
    endcase
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios with literal
// expectations plus a randomized run compared every cycle against a model.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk;
  logic        rst_n;
  logic [8:0]  imem_ra;
  logic [31:0] imem_rd;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt_req;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_instr;
  logic        if_id_valid;
  logic        pc_oob;
  logic [31:0] fetch_count;
  logic        halted;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [0:127];

  // Model state: what the stage must hold according to its rules
  logic [31:0] m_pc;
  logic        m_boot;
  logic        m_halt;
  logic [31:0] m_if_pc;
  logic [31:0] m_if_instr;
  logic        m_if_valid;
  logic [31:0] m_count;

  fetch_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_ra        (imem_ra),
    .imem_rd        (imem_rd),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt_req       (halt_req),
    .if_id_pc       (if_id_pc),
    .if_id_instr    (if_id_instr),
    .if_id_valid    (if_id_valid),
    .pc_oob         (pc_oob),
    .fetch_count    (fetch_count),
    .halted         (halted)
  );

  // Free-running core clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: read on the falling edge, word-addressed
  always @(negedge clk) imem_rd = mem[imem_ra[8:2]];

  // Behavioural reference of the fetch stage
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc       <= 32'd0;
      m_boot     <= 1'b1;
      m_halt     <= 1'b0;
      m_if_pc    <= 32'd0;
      m_if_instr <= NOP;
      m_if_valid <= 1'b0;
      m_count    <= 32'd0;
    end else if (m_boot) begin
      m_boot     <= 1'b0;
      m_if_instr <= NOP;
      m_if_valid <= 1'b0;
    end else if (redirect_valid) begin
      m_pc       <= {redirect_pc[31:2], 2'b00};
      m_halt     <= 1'b0;
      m_if_instr <= NOP;
      m_if_valid <= 1'b0;
    end else if (m_halt || halt_req) begin
      m_halt     <= 1'b1;
      m_if_instr <= NOP;
      m_if_valid <= 1'b0;
    end else if (!stall) begin
      m_if_pc    <= m_pc;
      m_if_instr <= mem[m_pc[8:2]];
      m_if_valid <= 1'b1;
      m_pc       <= m_pc + 32'd4;
      m_count    <= m_count + 32'd1;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Every cycle out of reset, compare DUT outputs against the model
  always @(negedge clk) begin
    if (rst_n) begin
      checkOutput("cmp imem_ra", {23'd0, imem_ra}, {23'd0, m_pc[8:0]});
      checkOutput("cmp pc_oob", {31'd0, pc_oob}, {31'd0, (m_pc >= 32'd512)});
      checkOutput("cmp if_id_valid", {31'd0, if_id_valid}, {31'd0, m_if_valid});
      checkOutput("cmp if_id_instr", if_id_instr, m_if_instr);
      if (m_if_valid) checkOutput("cmp if_id_pc", if_id_pc, m_if_pc);
      checkOutput("cmp fetch_count", fetch_count, m_count);
      checkOutput("cmp halted", {31'd0, halted}, {31'd0, m_halt});
    end
  end

  // Drive one cycle of inputs, then return at the following falling edge
  task automatic applyStimulus(input logic s, input logic rv,
                               input logic [31:0] rp, input logic h);
    stall          = s;
    redirect_valid = rv;
    redirect_pc    = rp;
    halt_req       = h;
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = $urandom;
    rst_n = 1'b0;
    stall = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'd0;
    halt_req = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] reset values");
    checkOutput("rst if_id_valid", {31'd0, if_id_valid}, 32'd0);
    checkOutput("rst if_id_instr", if_id_instr, NOP);
    checkOutput("rst if_id_pc", if_id_pc, 32'd0);
    checkOutput("rst fetch_count", fetch_count, 32'd0);
    checkOutput("rst halted", {31'd0, halted}, 32'd0);
    checkOutput("rst imem_ra", {23'd0, imem_ra}, 32'd0);
    rst_n = 1'b1;

    $display("[TB] boot bubble and sequential fetch");
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0);
    checkOutput("boot valid", {31'd0, if_id_valid}, 32'd0);
    checkOutput("boot imem_ra", {23'd0, imem_ra}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b0, 32'd0, 1'b0);
      checkOutput("seq if_id_pc", if_id_pc, 32'(i * 4));
      checkOutput("seq valid", {31'd0, if_id_valid}, 32'd1);
      checkOutput("seq instr", if_id_instr, mem[i]);
    end
    checkOutput("seq count", fetch_count, 32'd4);

    $display("[TB] stall hold");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, 32'd0, 1'b0);
      checkOutput("stall imem_ra", {23'd0, imem_ra}, 32'h10);
      checkOutput("stall if_id_pc", if_id_pc, 32'hC);
      checkOutput("stall instr", if_id_instr, mem[3]);
      checkOutput("stall count", fetch_count, 32'd4);
    end

    $display("[TB] halt and resume");
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
    checkOutput("halt halted", {31'd0, halted}, 32'd1);
    checkOutput("halt valid", {31'd0, if_id_valid}, 32'd0);
    checkOutput("halt instr", if_id_instr, NOP);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 1'b0, 32'd0, 1'b1);
      checkOutput("halt imem_ra", {23'd0, imem_ra}, 32'h10);
      checkOutput("halt stays", {31'd0, halted}, 32'd1);
    end
    checkOutput("halt count", fetch_count, 32'd4);
    applyStimulus(1'b0, 1'b1, 32'h20, 1'b0);
    checkOutput("resume halted", {31'd0, halted}, 32'd0);
    checkOutput("resume imem_ra", {23'd0, imem_ra}, 32'h20);
    checkOutput("resume valid", {31'd0, if_id_valid}, 32'd0);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0);
    checkOutput("resume if_id_pc", if_id_pc, 32'h20);
    checkOutput("resume count", fetch_count, 32'd5);

    $display("[TB] redirect with stall");
    applyStimulus(1'b1, 1'b1, 32'h41, 1'b0);
    checkOutput("redir imem_ra", {23'd0, imem_ra}, 32'h40);
    checkOutput("redir valid", {31'd0, if_id_valid}, 32'd0);
    checkOutput("redir instr", if_id_instr, NOP);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0);
    checkOutput("redir if_id_pc", if_id_pc, 32'h40);
    checkOutput("redir fetched", {31'd0, if_id_valid}, 32'd1);
    checkOutput("redir count", fetch_count, 32'd6);

    $display("[TB] pc wrap at top of address space");
    applyStimulus(1'b0, 1'b1, 32'hFFFFFFFC, 1'b0);
    checkOutput("wrap pc_oob high", {31'd0, pc_oob}, 32'd1);
    checkOutput("wrap imem_ra high", {23'd0, imem_ra}, 32'h1FC);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0);
    checkOutput("wrap if_id_pc", if_id_pc, 32'hFFFFFFFC);
    checkOutput("wrap instr", if_id_instr, mem[127]);
    checkOutput("wrap pc_oob low", {31'd0, pc_oob}, 32'd0);
    checkOutput("wrap imem_ra low", {23'd0, imem_ra}, 32'd0);
    checkOutput("wrap count", fetch_count, 32'd7);

    $display("[TB] randomized run");
    for (int i = 0; i < 2000; i++) begin
      logic [31:0] tgt;
      tgt = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 1023)) : $urandom;
      applyStimulus(1'($urandom_range(0, 99) < 20), 1'($urandom_range(0, 99) < 8),
                    tgt, 1'($urandom_range(0, 99) < 4));
    end

    $display("[TB] asynchronous reset mid-stream");
    applyStimulus(1'b0, 1'b1, 32'h8, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0);
    checkOutput("midrst pre valid", {31'd0, if_id_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst valid", {31'd0, if_id_valid}, 32'd0);
    checkOutput("midrst instr", if_id_instr, NOP);
    checkOutput("midrst if_id_pc", if_id_pc, 32'd0);
    checkOutput("midrst count", fetch_count, 32'd0);
    checkOutput("midrst halted", {31'd0, halted}, 32'd0);
    checkOutput("midrst imem_ra", {23'd0, imem_ra}, 32'd0);
    checkOutput("midrst pc_oob", {31'd0, pc_oob}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) applyStimulus(1'b0, 1'b0, 32'd0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
